// File: rtl/outbuf_pkg.sv
// Shared helpers for the elastic output buffer: width functions and the
// output-register load selector.
package outbuf_pkg;

  // Load decision for the output register on each edge.
  typedef enum logic [1:0] {
    LOAD_HOLD   = 2'd0,
    LOAD_FIFO   = 2'd1,
    LOAD_BYPASS = 2'd2,
    LOAD_CLEAR  = 2'd3
  } load_sel_e;

  // Valid flag sits directly above the payload.
  function automatic int valid_bit(input int w);
    return w;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy spans 0..DEPTH+1.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/outbuf_mem.sv
// Skid storage for outbuf_fifo: synchronous write, asynchronous head read.
module outbuf_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count define which entries
  // are meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/outbuf_fifo.sv
// Elastic output buffer: DEPTH-entry skid FIFO ahead of a registered output.
// Define OUTBUF_FIFO_LEVEL_EN to add the registered occupancy port 'level'.
module outbuf_fifo
  import outbuf_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W:0]            core_data,
  output logic                  core_stop,
  output logic [W:0]            out_data,
  input  logic                  out_stop
`ifdef OUTBUF_FIFO_LEVEL_EN
  ,
  output logic [lvl_w(DEPTH)-1:0] level
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int VB = valid_bit(W);

  typedef struct packed {
    logic         valid;
    logic [W-1:0] payload;
  } word_t;

  word_t        r_out;
  logic         r_core_stop;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  word_t        w_core;
  logic [W-1:0] w_head;
  logic         w_accept;
  logic         w_out_free;
  logic         w_fifo_empty;
  logic         w_push;
  logic         w_pop;
  logic [CW-1:0] w_cnt_next;
  load_sel_e    w_sel;

  assign w_core       = word_t'(core_data);
  assign w_accept     = core_data[VB] & ~r_core_stop;
  assign w_out_free   = ~r_out.valid | ~out_stop;
  assign w_fifo_empty = (r_cnt == '0);

  // Bypass only with an empty FIFO so a fresh word never overtakes stored ones.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_sel = LOAD_HOLD;
    if (w_out_free) begin
      if (!w_fifo_empty)  w_sel = LOAD_FIFO;
      else if (w_accept)  w_sel = LOAD_BYPASS;
      else                w_sel = LOAD_CLEAR;
    end
  end

  assign w_pop      = (w_sel == LOAD_FIFO);
  assign w_push     = w_accept & (w_sel != LOAD_BYPASS);
  assign w_cnt_next = r_cnt + CW'(w_push) - CW'(w_pop);

  outbuf_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_core.payload),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_core_stop <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
    end else begin
      case (w_sel)
        LOAD_FIFO:   r_out <= '{valid: 1'b1, payload: w_head};
        LOAD_BYPASS: r_out <= w_core;
        LOAD_CLEAR:  r_out.valid <= 1'b0;
        default:     r_out <= r_out;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt       <= w_cnt_next;
      r_core_stop <= (w_cnt_next == CW'(DEPTH));
    end
  end

  assign out_data  = r_out;
  assign core_stop = r_core_stop;

`ifdef OUTBUF_FIFO_LEVEL_EN
  localparam int LW = lvl_w(DEPTH);

  logic          w_out_valid_next;
  logic [LW-1:0] r_level;

  assign w_out_valid_next = (w_sel == LOAD_FIFO) || (w_sel == LOAD_BYPASS) ||
                            ((w_sel == LOAD_HOLD) && r_out.valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level <= '0;
    else        r_level <= LW'(w_cnt_next) + LW'(w_out_valid_next);
  end

  assign level = r_level;
`endif

endmodule

// File: tb/tb_outbuf_fifo.sv
// Directed self-checking bench for outbuf_fifo (W=8, DEPTH=4); level checks
// are active when OUTBUF_FIFO_LEVEL_EN is defined.
module tb_outbuf_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] core_data;
  logic       core_stop;
  logic [8:0] out_data;
  logic       out_stop;
`ifdef OUTBUF_FIFO_LEVEL_EN
  logic [2:0] level;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  outbuf_fifo #(.W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_data (core_data),
    .core_stop (core_stop),
    .out_data  (out_data),
    .out_stop  (out_stop)
`ifdef OUTBUF_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  typedef struct {
    logic [8:0] cd;
    logic       os;
    logic [8:0] exp_out;
    logic       exp_stop;
    logic [2:0] exp_lvl;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lvl(input string name, input logic [2:0] exp);
`ifdef OUTBUF_FIFO_LEVEL_EN
    check(name, {29'd0, level}, {29'd0, exp});
`endif
  endtask

  initial begin
    // Single word, fill under stall, drain from full, push+pop at 2 entries,
    // interleaved invalid words.
    tbl[0]  = '{9'h1A5, 1'b0, 9'h1A5, 1'b0, 3'd1};
    tbl[1]  = '{9'h000, 1'b0, 9'h0A5, 1'b0, 3'd0};
    tbl[2]  = '{9'h101, 1'b1, 9'h101, 1'b0, 3'd1};
    tbl[3]  = '{9'h102, 1'b1, 9'h101, 1'b0, 3'd2};
    tbl[4]  = '{9'h103, 1'b1, 9'h101, 1'b0, 3'd3};
    tbl[5]  = '{9'h104, 1'b1, 9'h101, 1'b0, 3'd4};
    tbl[6]  = '{9'h105, 1'b1, 9'h101, 1'b1, 3'd5};
    tbl[7]  = '{9'h106, 1'b1, 9'h101, 1'b1, 3'd5};
    tbl[8]  = '{9'h106, 1'b0, 9'h102, 1'b0, 3'd4};
    tbl[9]  = '{9'h106, 1'b0, 9'h103, 1'b0, 3'd4};
    tbl[10] = '{9'h000, 1'b0, 9'h104, 1'b0, 3'd3};
    tbl[11] = '{9'h000, 1'b0, 9'h105, 1'b0, 3'd2};
    tbl[12] = '{9'h000, 1'b0, 9'h106, 1'b0, 3'd1};
    tbl[13] = '{9'h000, 1'b0, 9'h006, 1'b0, 3'd0};
    tbl[14] = '{9'h111, 1'b1, 9'h111, 1'b0, 3'd1};
    tbl[15] = '{9'h112, 1'b1, 9'h111, 1'b0, 3'd2};
    tbl[16] = '{9'h113, 1'b1, 9'h111, 1'b0, 3'd3};
    tbl[17] = '{9'h114, 1'b0, 9'h112, 1'b0, 3'd3};
    tbl[18] = '{9'h115, 1'b0, 9'h113, 1'b0, 3'd3};
    tbl[19] = '{9'h116, 1'b0, 9'h114, 1'b0, 3'd3};
    tbl[20] = '{9'h0AB, 1'b0, 9'h115, 1'b0, 3'd2};
    tbl[21] = '{9'h117, 1'b0, 9'h116, 1'b0, 3'd2};
    tbl[22] = '{9'h0CD, 1'b0, 9'h117, 1'b0, 3'd1};
    tbl[23] = '{9'h0EF, 1'b0, 9'h017, 1'b0, 3'd0};
    tbl[24] = '{9'h1C3, 1'b0, 9'h1C3, 1'b0, 3'd1};
    tbl[25] = '{9'h055, 1'b1, 9'h1C3, 1'b0, 3'd1};
    tbl[26] = '{9'h000, 1'b0, 9'h0C3, 1'b0, 3'd0};

    rst_n     = 1'b0;
    core_data = 9'h000;
    out_stop  = 1'b0;
    #12;
    check("reset out_data", {23'd0, out_data}, 32'h000);
    check("reset core_stop", {31'd0, core_stop}, 32'd0);
    check_lvl("reset level", 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      core_data = tbl[i].cd;
      out_stop  = tbl[i].os;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_data", i), {23'd0, out_data}, {23'd0, tbl[i].exp_out});
      check($sformatf("vec%0d core_stop", i), {31'd0, core_stop}, {31'd0, tbl[i].exp_stop});
      check_lvl($sformatf("vec%0d level", i), tbl[i].exp_lvl);
    end

    // Fill to full under stall, then reset asynchronously between edges.
    out_stop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      core_data = 9'h131 + 9'(k);
      @(posedge clk);
      #1;
    end
    check("full core_stop", {31'd0, core_stop}, 32'd1);
    check("full out_data", {23'd0, out_data}, 32'h131);
    check_lvl("full level", 3'd5);
    core_data = 9'h136;
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", {31'd0, out_data[8]}, 32'd0);
    check("async rst core_stop", {31'd0, core_stop}, 32'd0);
    check_lvl("async rst level", 3'd0);
    #1 rst_n = 1'b1;
    out_stop  = 1'b0;
    core_data = 9'h1D7;
    #1;
    check_lvl("post rst level before", 3'd0);
    @(posedge clk);
    #1;
    check("post rst bypass", {23'd0, out_data}, 32'h1D7);
    check("post rst core_stop", {31'd0, core_stop}, 32'd0);
    check_lvl("post rst level after", 3'd1);
    core_data = 9'h000;
    @(posedge clk);
    #1;
    check("post rst no stale 1", {23'd0, out_data}, 32'h0D7);
    @(posedge clk);
    #1;
    check("post rst no stale 2", {23'd0, out_data}, 32'h0D7);
    check_lvl("post rst level empty", 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
